// File: rtl/shift_unit_pipe_pkg.sv
// shift_pkg: op codes, legality check and fill-mode encodings shared by the shift pipeline
package shift_pkg;
   typedef enum logic [2:0] {
      OP_LSL = 3'd0,
      OP_LSR = 3'd1,
      OP_ASR = 3'd2,
      OP_ROR = 3'd3,
      OP_ROL = 3'd4
   } op_t;
   typedef enum logic [1:0] {
      FILL_ZERO = 2'd0,
      FILL_SIGN = 2'd1,
      FILL_ROT  = 2'd2
   } fill_t;
   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_ROL;
   endfunction
endpackage

// File: rtl/shift_unit_pipe_if.sv
// shift_unit_pipe_if: request/result valid-ready bundle of the shift pipeline
interface shift_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic             out_err;
   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
   );
   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero, out_err
   );
endinterface

// File: rtl/shift_unit_pipe_layer.sv
// shift_layer: one registered right-shift mux layer of distance DIST, carrying the request sideband
module shift_layer import shift_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DIST  = 1
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       en,
   input  logic                       valid_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic [$clog2(WIDTH)-1:0]   amt_i,
   input  fill_t                      fill_i,
   input  logic                       rev_i,
   input  logic                       carry_i,
   input  logic                       err_i,
   output logic                       valid_q,
   output logic [WIDTH-1:0]           data_q,
   output logic [$clog2(WIDTH)-1:0]   amt_q,
   output fill_t                      fill_q,
   output logic                       rev_q,
   output logic                       carry_q,
   output logic                       err_q
);
   localparam int B = $clog2(DIST);
   logic [DIST-1:0]  fill_bits;
   logic [WIDTH-1:0] data_d;
   always_comb begin
      fill_bits = fill_i == FILL_ROT ? data_i[DIST-1:0] : fill_i == FILL_SIGN ? {DIST{data_i[WIDTH-1]}} : '0;
      data_d = amt_i[B] ? {fill_bits, data_i[WIDTH-1:DIST]} : data_i;
   end
   always_ff @(posedge CLK)
      if (!RESET_N) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         amt_q   <= '0;
         fill_q  <= FILL_ZERO;
         rev_q   <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (en) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         amt_q   <= amt_i;
         fill_q  <= fill_i;
         rev_q   <= rev_i;
         carry_q <= carry_i;
         err_q   <= err_i;
      end
endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined LSL/LSR/ASR/ROR/ROL shifter with carry/zero/err flags behind valid/ready
module shift_unit_pipe import shift_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8
) (
   input logic              CLK,
   input logic              RESET_N,
   shift_unit_pipe_if.slave bus
);
   localparam int K = $clog2(WIDTH);
   logic                 stall, en, legal, left, sat, msb;
   logic [31:0]          n32;
   logic [K-1:0]         dec_idx, neg_idx;
   logic [WIDTH-1:0]     rev_in, rev_out;
   logic                 s0_valid_d, s0_valid_q, s0_rev_d, s0_rev_q;
   logic                 s0_carry_d, s0_carry_q, s0_err_d, s0_err_q;
   logic [WIDTH-1:0]     s0_data_d, s0_data_q;
   logic [K-1:0]         s0_amt_d, s0_amt_q;
   fill_t                s0_fill_d, s0_fill_q;
   logic [K:0]           v, r, c, e;
   logic [K:0][WIDTH-1:0] d;
   logic [K:0][K-1:0]    a;
   fill_t                f [K+1];
   logic                 unused_tail;
   assign stall = bus.out_valid && !bus.out_ready;
   assign en = !stall;
   assign bus.in_ready = !stall;
   // Saturating shifts are resolved here so the layers only ever see in-range amounts.
   always_comb begin
      legal = op_legal(bus.in_op);
      left = legal && (bus.in_op == OP_LSL || bus.in_op == OP_ROL);
      msb = bus.in_data[WIDTH-1];
      n32 = 32'(bus.in_amt);
      dec_idx = K'(bus.in_amt - AMT_W'(1));
      neg_idx = K'(AMT_W'(0) - bus.in_amt);
      rev_in = {<<{bus.in_data}};
      sat = legal && n32 >= 32'(WIDTH) && (bus.in_op == OP_LSL || bus.in_op == OP_LSR || bus.in_op == OP_ASR);
      s0_carry_d = !legal || bus.in_amt == '0 ? 1'b0
         : bus.in_op == OP_LSL ? n32 <= 32'(WIDTH) && bus.in_data[neg_idx]
         : bus.in_op == OP_LSR ? n32 <= 32'(WIDTH) && bus.in_data[dec_idx]
         : bus.in_op == OP_ASR ? (n32 >= 32'(WIDTH) ? msb : bus.in_data[dec_idx])
         : bus.in_op == OP_ROR ? bus.in_data[dec_idx] : bus.in_data[neg_idx];
      s0_data_d = sat ? (bus.in_op == OP_ASR ? {WIDTH{msb}} : '0) : left ? rev_in : bus.in_data;
      s0_amt_d = legal && !sat ? bus.in_amt[K-1:0] : '0;
      s0_fill_d = bus.in_op == OP_ASR ? FILL_SIGN : (bus.in_op == OP_ROR || bus.in_op == OP_ROL) ? FILL_ROT : FILL_ZERO;
      s0_valid_d = bus.in_valid && bus.in_ready;
      s0_rev_d = left;
      s0_err_d = !legal;
   end
   always_ff @(posedge CLK)
      if (!RESET_N) begin
         s0_valid_q <= 1'b0;
         s0_data_q  <= '0;
         s0_amt_q   <= '0;
         s0_fill_q  <= FILL_ZERO;
         s0_rev_q   <= 1'b0;
         s0_carry_q <= 1'b0;
         s0_err_q   <= 1'b0;
      end else if (en) begin
         s0_valid_q <= s0_valid_d;
         s0_data_q  <= s0_data_d;
         s0_amt_q   <= s0_amt_d;
         s0_fill_q  <= s0_fill_d;
         s0_rev_q   <= s0_rev_d;
         s0_carry_q <= s0_carry_d;
         s0_err_q   <= s0_err_d;
      end
   assign v[0] = s0_valid_q;
   assign d[0] = s0_data_q;
   assign a[0] = s0_amt_q;
   assign f[0] = s0_fill_q;
   assign r[0] = s0_rev_q;
   assign c[0] = s0_carry_q;
   assign e[0] = s0_err_q;
   for (genvar i = 0; i < K; i++) begin : g_layer
      shift_layer #(.WIDTH(WIDTH), .DIST(1 << i)) u_layer (
         .CLK(CLK), .RESET_N(RESET_N), .en(en),
         .valid_i(v[i]), .data_i(d[i]), .amt_i(a[i]), .fill_i(f[i]), .rev_i(r[i]), .carry_i(c[i]), .err_i(e[i]),
         .valid_q(v[i+1]), .data_q(d[i+1]), .amt_q(a[i+1]), .fill_q(f[i+1]), .rev_q(r[i+1]), .carry_q(c[i+1]), .err_q(e[i+1])
      );
   end
   assign rev_out = {<<{d[K]}};
   assign bus.out_valid = v[K];
   assign bus.out_data = r[K] ? rev_out : d[K];
   assign bus.out_carry = c[K];
   assign bus.out_err = e[K];
   assign bus.out_zero = v[K] && d[K] == '0;
   assign unused_tail = ^{a[K], f[K]};
endmodule
